param_pipelined_multiplier: RTL

PARAM_PIPELINED_MULTIPLIER -- requirements
Module: param_pipelined_multiplier

---
 rtl/param_pipelined_multiplier.sv | 104 ++++++++++
 1 files changed

// File: rtl/param_pipelined_multiplier.sv
// Pipelined WIDTH x WIDTH multiplier with per-beat signed/unsigned mode, a sideband tag and
// valid/ready flow control. The whole pipeline freezes while the output is stalled.
module param_pipelined_multiplier #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_in,
    output logic                          ready_in,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    input  logic                          signed_mode,
    input  logic [TAG_W-1:0]              tag_in,
    output logic                          valid_out,
    input  logic                          ready_out,
    output logic [2*WIDTH-1:0]            result,
    output logic [TAG_W-1:0]              tag_out,
    output logic [$clog2(STAGES+1)-1:0]   in_flight
);

    localparam int CNT_W = $clog2(STAGES + 1);

    logic               stall;
    logic               in_xfer;
    logic               out_xfer;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] product;

    logic               valid_q [STAGES];
    logic               valid_d [STAGES];
    logic [2*WIDTH-1:0] data_q  [STAGES];
    logic [2*WIDTH-1:0] data_d  [STAGES];
    logic [TAG_W-1:0]   tag_q   [STAGES];
    logic [TAG_W-1:0]   tag_d   [STAGES];
    logic [CNT_W-1:0]   in_flight_q;
    logic [CNT_W-1:0]   in_flight_d;

    assign stall     = valid_q[STAGES-1] && !ready_out;
    assign ready_in  = !stall;
    assign in_xfer   = valid_in && ready_in;
    assign out_xfer  = valid_q[STAGES-1] && ready_out;

    assign valid_out = valid_q[STAGES-1];
    assign result    = data_q[STAGES-1];
    assign tag_out   = tag_q[STAGES-1];
    assign in_flight = in_flight_q;

    // The low 2*WIDTH bits of the product of the 2*WIDTH-bit extended operands are exact in both
    // modes, so the mode is consumed here and the stages behind only carry it folded into the data.
    always_comb begin
        a_ext   = {{WIDTH{signed_mode & a[WIDTH-1]}}, a};
        b_ext   = {{WIDTH{signed_mode & b[WIDTH-1]}}, b};
        product = a_ext * b_ext;
    end

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            valid_d[i] = valid_q[i];
            data_d[i]  = data_q[i];
            tag_d[i]   = tag_q[i];
        end
        if (!stall) begin
            valid_d[0] = in_xfer;
            data_d[0]  = product;
            tag_d[0]   = tag_in;
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
                tag_d[i]   = tag_q[i-1];
            end
        end
    end

    always_comb begin
        in_flight_d = in_flight_q;
        if (in_xfer && !out_xfer) begin
            in_flight_d = in_flight_q + CNT_W'(1);
        end else if (!in_xfer && out_xfer) begin
            in_flight_d = in_flight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
                tag_q[i]   <= '0;
            end
            in_flight_q <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= valid_d[i];
                data_q[i]  <= data_d[i];
                tag_q[i]   <= tag_d[i];
            end
            in_flight_q <= in_flight_d;
        end
    end

endmodule
